// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and the inverse-cipher FSM state type.
package aes_pkg;

    localparam int unsigned NB        = 4;
    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [0:0] {IDLE, RUN} dec_fsm_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; i_last skips InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] i_state,
    input  logic [AES_BLK_W-1:0] i_key,
    input  logic                 i_last,
    output logic [AES_BLK_W-1:0] o_state
);

    function automatic logic [AES_BLK_W-1:0] inv_round(input logic [AES_BLK_W-1:0] st,
                                                       input logic [AES_BLK_W-1:0] key,
                                                       input logic             last);
        logic [7:0] b [16];
        logic [7:0] s [16];
        logic [7:0] a0, a1, a2, a3;
        logic [AES_BLK_W-1:0] res;
        for (int i = 0; i < 16; i++) b[i] = st[AES_BLK_W-1-8*i -: 8];
        // Byte 4c+r holds row r of column c; row r rotates right by r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[4*c+r] = INV_SBOX[b[4*((c + 4 - r) % 4) + r]]
                         ^ key[AES_BLK_W-1-8*(4*c+r) -: 8];
            end
        end
        res = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            if (last) begin
                res[AES_BLK_W-1-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                res[AES_BLK_W-1-32*c -: 32] = {
                    gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                    gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                    gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                    gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
                };
            end
        end
        return res;
    endfunction

    assign o_state = inv_round(i_state, i_key, i_last);

endmodule

// File: rtl/aes_block_dec.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched by index.
// Define AES_DEC_ZEROIZE_EN to clear outData on accept and the state on completion.
module aes_block_dec
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS = 14
) (
    input  logic                 inClk,
    input  logic                 inRst,
    input  logic                 inDataWr,
    input  logic [AES_BLK_W-1:0] inDataData,
    input  logic [AES_BLK_W-1:0] inKeyData,
    output logic [3:0]           outRoundIdx,
    output logic [AES_BLK_W-1:0] outData,
    output logic                 outValid,
    output logic                 outBusy
);

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

    dec_fsm_e             r_fsm, w_fsm_nxt;
    logic [AES_BLK_W-1:0] r_state, w_state_nxt;
    logic [AES_BLK_W-1:0] r_data, w_data_nxt;
    logic [3:0]           r_idx, w_idx_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [AES_BLK_W-1:0] w_round;

    aes_inv_round u_round (
        .i_state (r_state),
        .i_key   (inKeyData),
        .i_last  (r_idx == 4'd0),
        .o_state (w_round)
    );

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_data  <= '0;
            r_idx   <= LAST_IDX;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        unique case (r_fsm)
            IDLE: begin
                if (inDataWr) begin
                    w_fsm_nxt   = RUN;
                    w_state_nxt = inDataData ^ inKeyData;
                    w_idx_nxt   = LAST_IDX - 4'd1;
                    w_busy_nxt  = 1'b1;
`ifdef AES_DEC_ZEROIZE_EN
                    w_data_nxt  = '0;
`endif
                end
            end
            RUN: begin
                if (r_idx == 4'd0) begin
                    w_fsm_nxt   = IDLE;
                    w_data_nxt  = w_round;
                    w_idx_nxt   = LAST_IDX;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
                    w_state_nxt = '0;
`endif
                end else begin
                    w_state_nxt = w_round;
                    w_idx_nxt   = r_idx - 4'd1;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    assign outRoundIdx = r_idx;
    assign outData     = r_data;
    assign outValid    = r_valid;
    assign outBusy     = r_busy;

endmodule

// File: tb/tb_aes_block_dec.sv
// Directed and randomized checks of aes_block_dec against a forward-cipher reference model.
module tb_aes_block_dec;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr;
    logic [127:0] din;
    logic [127:0] kin;
    logic [3:0]   idx;
    logic [127:0] dout;
    logic         vld;
    logic         busy;

    logic [127:0] rk [15];
    logic [7:0]   sb [256];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    // Bench-side round-key store, indexed by the DUT.
    assign kin = rk[idx];

    aes_block_dec #(.ROUNDS(14)) dut (
        .inClk       (clk),
        .inRst       (rst),
        .inDataWr    (wr),
        .inDataData  (din),
        .inKeyData   (kin),
        .outRoundIdx (idx),
        .outData     (dout),
        .outValid    (vld),
        .outBusy     (busy)
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box from the field inverse plus the affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < 15; r++) begin
            for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c+w] = a[4*((c + w) % 4) + w];
            for (int c = 0; c < 4; c++) begin
                x0 = t[4*c]; x1 = t[4*c+1]; x2 = t[4*c+2]; x3 = t[4*c+3];
                if (r < 14)
                    s[127-32*c -: 32] = {gm(x0, 8'h02) ^ gm(x1, 8'h03) ^ x2 ^ x3,
                                         x0 ^ gm(x1, 8'h02) ^ gm(x2, 8'h03) ^ x3,
                                         x0 ^ x1 ^ gm(x2, 8'h02) ^ gm(x3, 8'h03),
                                         gm(x0, 8'h03) ^ x1 ^ x2 ^ gm(x3, 8'h02)};
                else
                    s[127-32*c -: 32] = {x0, x1, x2, x3};
            end
            s = s ^ rk[r];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [127:0] ct);
        din = ct;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until outValid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (vld !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int           lat;
        int           pulses;
        int           guard;
        logic [127:0] got;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] last_pt;
        logic [255:0] key;

        rst = 1'b1;
        wr  = 1'b0;
        din = '0;
        build_sbox();
        expand(C3_KEY);
        #12;
        check("rst_idx", idx, 14);
        check("rst_data", dout, 0);
        check("rst_valid", vld, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // C.3 vector with round-index sequence and busy/valid timing
        check("idle_idx", idx, 14);
        strobe(C3_CT);
        for (int t = 1; t <= 14; t++) begin
            check("idx_seq", idx, 128'(14 - t));
            check("busy_run", {busy, vld}, 2'b10);
            tick();
        end
        check("c3_valid", vld, 1);
        check("c3_busy_fall", busy, 0);
        check("c3_idx_wrap", idx, 14);
        check("c3_data", dout, C3_PT);

        // Back-to-back accept in the outValid cycle
        strobe(C3_CT);
        check("pulse_one", vld, 0);
        wait_valid(lat);
        check("b2b_lat", lat, 15);
        check("b2b_data", dout, C3_PT);

        // Strobe while busy is ignored
        tick();
        strobe(C3_CT);
        guard = 0;
        while (idx != 4'd7 && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_r7", idx, 7);
        din = '0;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        pulses = 0;
        got    = '0;
        for (int i = 0; i < 25; i++) begin
            if (vld === 1'b1) begin
                pulses++;
                got = dout;
            end
            tick();
        end
        check("busy_ign_pulses", pulses, 1);
        check("busy_ign_data", got, C3_PT);
        check("busy_ign_idle", busy, 0);

        // Asynchronous reset mid-block
        strobe(C3_CT);
        guard = 0;
        while (idx != 4'd5 && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_r5", idx, 5);
        #2 rst = 1'b1;
        #1;
        check("arst_idx", idx, 14);
        check("arst_data", dout, 0);
        check("arst_valid", vld, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (vld === 1'b1) pulses++;
            tick();
        end
        check("arst_no_valid", pulses, 0);
        strobe(C3_CT);
        wait_valid(lat);
        check("post_rst_lat", lat, 15);
        check("post_rst_data", dout, C3_PT);
        last_pt = C3_PT;

        // Random round-trip through the reference encryptor
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            ct = enc(pt);
            strobe(ct);
`ifdef AES_DEC_ZEROIZE_EN
            check("rt_zeroize", dout, 0);
`else
            check("rt_hold", dout, last_pt);
`endif
            wait_valid(lat);
            check("rt_lat", lat, 15);
            check("rt_data", dout, pt);
            last_pt = pt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
